fifo_burst_wr_arbiter: RTL and testbench
========================================

# fifo_burst_wr_arbiter

Round-robin write-side arbiter that shares one synchronous distributed FIFO (SYNC_FIFO configuration) among NUM_REQ producers. Each grant transfers exactly BURST_LEN words, one 3x3 matrix by default, so matrices from different producers never interleave in the FIFO. A burst is granted only when the FIFO has room for the whole burst. The block sits between the matrix producers and the FIFO write port and drives the FIFO's write data and write enable.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_WIDTH, 32, word width; must equal the FIFO DATA_WIDTH
- ADDR_WIDTH, 10, FIFO address width; FIFO depth = 2^ADDR_WIDTH
- BURST_LEN, 9, words per grant (1..2^ADDR_WIDTH)
- TIMEOUT_CYC, 16, stall limit in cycles; used only when FIFO_ARB_PAD_EN is defined

- clk  in  1  single clock; the FIFO's wr_clk and rd_clk are tied to this clock
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester word valid
- req_data  in  NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready  out  NUM_REQ  per-requester word accept; one-hot or zero
- fifo_wr_data  out  DATA_WIDTH  to FIFO wr_data
- fifo_wr_en  out  1  to FIFO wr_en
- fifo_full  in  1  from FIFO full
- fifo_wr_water_level  in  ADDR_WIDTH+1  from FIFO wr_water_level
- grant_id  out  $clog2(NUM_REQ)  index of the current owner; holds its last value in IDLE
- busy  out  1  high while in GRANT
- pad_err  out  1  sticky timeout flag; always 0 when FIFO_ARB_PAD_EN is undefined

## Operation
- Reset values (all outputs): req_ready=0, fifo_wr_en=0, fifo_wr_data=0, grant_id=0, busy=0, pad_err=0. Internal: rr_ptr=0, burst_cnt=0, state=IDLE.
- Free space is computed as free = 2^ADDR_WIDTH − fifo_wr_water_level − inflight.
  - Width is ADDR_WIDTH+2, unsigned.
  - inflight is 1 when fifo_wr_en is high, otherwise 0.
- State IDLE:
  - If any req_valid is high and free ≥ BURST_LEN: choose the first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - Load grant_id with that index, clear burst_cnt, and go to GRANT.
  - Otherwise stay in IDLE.
- State GRANT:
  - req_ready[grant_id] = !fifo_full. This is combinational from the state, grant_id and fifo_full. All other ready bits are 0.
  - A word transfers when req_valid[grant_id] && req_ready[grant_id]; each transfer increments burst_cnt.
  - On the transfer where burst_cnt == BURST_LEN−1: set rr_ptr=(grant_id+1) mod NUM_REQ and go to IDLE.
- Write path is registered. On the edge after a transfer, fifo_wr_en=1 and fifo_wr_data=that word. Otherwise fifo_wr_en=0 and fifo_wr_data holds its value.
- Non-granted requesters are not starved: once the current burst ends, the rotation guarantees each pending requester a grant within NUM_REQ−1 further bursts.
- A requester that drops req_valid mid-burst keeps the grant; the arbiter waits indefinitely (unless FIFO_ARB_PAD_EN is defined).
- fifo_full asserting during GRANT stalls the burst with no word lost. The space reservation normally prevents this; the gate is a safety net.
- Reset mid-burst: on the next edge every register returns to its reset value. Words already written stay in the FIFO, so the FIFO's own reset must be asserted with rst_n if alignment matters.

## Timing
- Grant latency: a request seen in IDLE gives req_ready high in the next cycle, unless fifo_full.
- Write latency: req handshake at edge N gives fifo_wr_en high during the cycle after N (1 cycle).
- Throughput: 1 word per cycle within a burst.
- Burst overhead: 1 IDLE cycle between consecutive bursts. A burst of length BURST_LEN with continuous valid occupies BURST_LEN+1 cycles.
- IDLE uses the current cycle's fifo_wr_water_level plus the inflight correction. No other FIFO latency is assumed.

## Configuration
- Macro FIFO_ARB_PAD_EN.
- Defined:
  - A stall counter counts GRANT cycles with !req_valid[grant_id] && !fifo_full, and clears on each transfer.
  - On reaching TIMEOUT_CYC, state goes to PAD. PAD drops req_ready and writes zero words, one per cycle while !fifo_full, until burst_cnt reaches BURST_LEN.
  - PAD then sets pad_err=1 (sticky until reset), advances rr_ptr past the owner, and returns to IDLE.
- Undefined: no PAD state and no stall counter; the grant waits forever and pad_err is tied to 0.

## Test plan
- Single requester 0, valid continuous, 9 words 1..9 → fifo_wr_en high 9 consecutive cycles starting 2 cycles after valid, data 1..9, busy low for 1 cycle afterwards.
- All 4 requesters valid continuously, starting from reset → grant_id sequence 0,1,2,3,0; each burst is 9 contiguous FIFO words from one source.
- fifo_wr_water_level = 1016 (free 8 < 9) with requester 2 valid → no grant. Lowering it to 1015 → grant to requester 2 next cycle.
- fifo_full forced high for 3 cycles mid-burst after word 4 → no writes during those cycles, then words 5..9 written, 9 total, none duplicated.
- FIFO_ARB_PAD_EN defined, TIMEOUT_CYC=16, requester 1 stops after 5 words → after 16 stall cycles, 4 zero words are written and pad_err=1, then requester 2 is granted.
- rst_n low for one cycle after word 3 of a burst → next cycle all outputs at reset values; the next grant goes to requester 0 starting a fresh 9-word count.

Source files
------------

// File: rtl/fifo_burst_wr_arbiter.sv
// Round-robin burst write arbiter in front of a shared synchronous FIFO; each grant writes BURST_LEN
// contiguous words. Optional timeout/zero-padding of stalled bursts under FIFO_ARB_PAD_EN.
module fifo_burst_wr_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 10,
  parameter int unsigned BURST_LEN   = 9,
  parameter int unsigned TIMEOUT_CYC = 16,
  localparam int unsigned IdW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  output logic [DATA_WIDTH-1:0]         fifo_wr_data_o,
  output logic                          fifo_wr_en_o,
  input  logic                          fifo_full_i,
  input  logic [ADDR_WIDTH:0]           fifo_wr_water_level_i,
  output logic [IdW-1:0]                grant_id_o,
  output logic                          busy_o,
  output logic                          pad_err_o
);

  localparam int unsigned CntW  = ADDR_WIDTH + 1;
  localparam int unsigned FreeW = ADDR_WIDTH + 2;

`ifdef FIFO_ARB_PAD_EN
  typedef enum logic [1:0] {StIdle, StGrant, StPad} state_e;
  localparam int unsigned StallW = $clog2(TIMEOUT_CYC + 1);
  logic [StallW-1:0] stall_cnt_q, stall_cnt_d;
  logic              pad_err_q, pad_err_d;
`else
  typedef enum logic [1:0] {StIdle, StGrant} state_e;
`endif

  state_e                state_q, state_d;
  logic [IdW-1:0]        grant_id_q, grant_id_d;
  logic [IdW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]       burst_cnt_q, burst_cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;

  logic [DATA_WIDTH-1:0] req_word [NUM_REQ];
  logic [FreeW-1:0]      free_space;
  logic                  pick_found;
  logic [IdW-1:0]        pick_idx;
  logic [IdW-1:0]        scan_idx;
  logic [IdW-1:0]        next_id;
  logic                  last_word;
  logic                  xfer;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_word
    assign req_word[g] = req_data_i[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // The word registered last cycle is not yet visible in the water level.
  assign free_space = FreeW'(1 << ADDR_WIDTH) - FreeW'(fifo_wr_water_level_i) - FreeW'(wr_en_q);
  assign next_id    = (grant_id_q == IdW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;
  assign last_word  = (burst_cnt_q == CntW'(BURST_LEN - 1));

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan_idx   = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_found && req_valid_i[scan_idx]) begin
        pick_found = 1'b1;
        pick_idx   = scan_idx;
      end
      scan_idx = (scan_idx == IdW'(NUM_REQ - 1)) ? '0 : scan_idx + 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_id_d  = grant_id_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    wr_en_d     = 1'b0;
    wr_data_d   = wr_data_q;
    req_ready_o = '0;
    busy_o      = 1'b0;
    xfer        = 1'b0;
`ifdef FIFO_ARB_PAD_EN
    stall_cnt_d = stall_cnt_q;
    pad_err_d   = pad_err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (pick_found && (free_space >= FreeW'(BURST_LEN))) begin
          grant_id_d  = pick_idx;
          burst_cnt_d = '0;
          state_d     = StGrant;
`ifdef FIFO_ARB_PAD_EN
          stall_cnt_d = '0;
`endif
        end
      end
      StGrant: begin
        busy_o                  = 1'b1;
        req_ready_o[grant_id_q] = !fifo_full_i;
        xfer                    = req_valid_i[grant_id_q] && !fifo_full_i;
        if (xfer) begin
          wr_en_d     = 1'b1;
          wr_data_d   = req_word[grant_id_q];
          burst_cnt_d = burst_cnt_q + 1'b1;
`ifdef FIFO_ARB_PAD_EN
          stall_cnt_d = '0;
`endif
          if (last_word) begin
            rr_ptr_d = next_id;
            state_d  = StIdle;
          end
        end
`ifdef FIFO_ARB_PAD_EN
        else if (!fifo_full_i) begin
          if (stall_cnt_q == StallW'(TIMEOUT_CYC - 1)) begin
            stall_cnt_d = '0;
            state_d     = StPad;
          end else begin
            stall_cnt_d = stall_cnt_q + 1'b1;
          end
        end
`endif
      end
`ifdef FIFO_ARB_PAD_EN
      StPad: begin
        // Fill the rest of the burst with zeros so FIFO framing stays aligned.
        if (!fifo_full_i) begin
          wr_en_d     = 1'b1;
          wr_data_d   = '0;
          burst_cnt_d = burst_cnt_q + 1'b1;
          if (last_word) begin
            pad_err_d = 1'b1;
            rr_ptr_d  = next_id;
            state_d   = StIdle;
          end
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      grant_id_q  <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
`ifdef FIFO_ARB_PAD_EN
      stall_cnt_q <= '0;
      pad_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
`ifdef FIFO_ARB_PAD_EN
      stall_cnt_q <= stall_cnt_d;
      pad_err_q   <= pad_err_d;
`endif
    end
  end

  assign fifo_wr_en_o   = wr_en_q;
  assign fifo_wr_data_o = wr_data_q;
  assign grant_id_o     = grant_id_q;
`ifdef FIFO_ARB_PAD_EN
  assign pad_err_o = pad_err_q;
`else
  assign pad_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_burst_wr_arbiter.sv
// Directed bench for fifo_burst_wr_arbiter; producers emit words {source<<16 | n}, n from 1.
module tb_fifo_burst_wr_arbiter;
  localparam int NR = 4;
  localparam int DW = 32;
  localparam int AW = 10;
  localparam int BL = 9;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic [DW-1:0]    fifo_wr_data;
  logic             fifo_wr_en;
  logic             fifo_full;
  logic [AW:0]      water;
  logic [1:0]       grant_id;
  logic             busy;
  logic             pad_err;

  always #5 clk = ~clk;

  fifo_burst_wr_arbiter #(
    .NUM_REQ(NR), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL), .TIMEOUT_CYC(16)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_data_i(req_data),
    .req_ready_o(req_ready), .fifo_wr_data_o(fifo_wr_data), .fifo_wr_en_o(fifo_wr_en),
    .fifo_full_i(fifo_full), .fifo_wr_water_level_i(water), .grant_id_o(grant_id),
    .busy_o(busy), .pad_err_o(pad_err)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cnt [NR];
  int rem [NR];
  int tk;
  logic          tr_en    [256];
  logic [DW-1:0] tr_data  [256];
  logic          tr_busy  [256];
  logic [1:0]    tr_gid   [256];
  logic [NR-1:0] tr_ready [256];
  logic          tr_pad   [256];

  function automatic logic [DW-1:0] word(input int src, input int n);
    return DW'((src << 16) | n);
  endfunction

  task automatic drive_req();
    for (int i = 0; i < NR; i++) begin
      req_valid[i]           = (rem[i] > 0);
      req_data[i*DW +: DW]   = word(i, cnt[i] + 1);
    end
  endtask

  task automatic tick();
    logic [NR-1:0] hs;
    #2;
    hs = req_valid & req_ready & {NR{rst_n}};
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) if (hs[i]) begin cnt[i]++; rem[i]--; end
    drive_req();
    tk++;
    if (tk < 256) begin
      tr_en[tk] = fifo_wr_en; tr_data[tk] = fifo_wr_data; tr_busy[tk] = busy;
      tr_gid[tk] = grant_id; tr_ready[tk] = req_ready; tr_pad[tk] = pad_err;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; fifo_full = 1'b0; water = '0;
    for (int i = 0; i < NR; i++) begin cnt[i] = 0; rem[i] = 0; end
    drive_req();
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic drain();
    int guard = 0;
    while ((rem[0] + rem[1] + rem[2] + rem[3] > 0 || busy || fifo_wr_en) && guard < 300) begin
      tick(); guard++;
    end
    n_cmp++;
    if (guard >= 300) begin n_err++; $display("FAIL drain_timeout got busy=%0b want idle", busy); end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp += 6;
    if (req_ready !== 4'b0)   begin n_err++; $display("FAIL rst_ready got %b want 0", req_ready); end
    if (fifo_wr_en !== 1'b0)  begin n_err++; $display("FAIL rst_wr_en got %b want 0", fifo_wr_en); end
    if (fifo_wr_data !== '0)  begin n_err++; $display("FAIL rst_data got %h want 0", fifo_wr_data); end
    if (grant_id !== 2'd0)    begin n_err++; $display("FAIL rst_gid got %0d want 0", grant_id); end
    if (busy !== 1'b0)        begin n_err++; $display("FAIL rst_busy got %b want 0", busy); end
    if (pad_err !== 1'b0)     begin n_err++; $display("FAIL rst_pad got %b want 0", pad_err); end
  endtask

  task automatic test_single();
    logic exp_en;
    do_reset();
    rem[0] = 18; drive_req(); tk = 0;
    repeat (12) tick();
    for (int k = 1; k <= 11; k++) begin
      exp_en = (k >= 2 && k <= 10);
      n_cmp += 2;
      if (tr_en[k] !== exp_en) begin n_err++; $display("FAIL single_en k=%0d got %b want %b", k, tr_en[k], exp_en); end
      if (tr_busy[k] !== (k != 10)) begin n_err++; $display("FAIL single_busy k=%0d got %b want %b", k, tr_busy[k], k != 10); end
      if (exp_en) begin
        n_cmp++;
        if (tr_data[k] !== word(0, k - 1)) begin n_err++; $display("FAIL single_data k=%0d got %h want %h", k, tr_data[k], word(0, k - 1)); end
      end
    end
    drain();
  endtask

  task automatic test_all4();
    int b, j;
    logic exp_en;
    do_reset();
    rem[0] = 18; rem[1] = 9; rem[2] = 9; rem[3] = 9; drive_req(); tk = 0;
    repeat (52) tick();
    for (int k = 1; k <= 51; k++) begin
      b = (k - 1) / 10; j = (k - 1) % 10;
      exp_en = (j != 0) && (b < 5);
      n_cmp++;
      if (tr_en[k] !== exp_en) begin n_err++; $display("FAIL rr_en k=%0d got %b want %b", k, tr_en[k], exp_en); end
      if (k <= 50) begin
        n_cmp++;
        if (tr_gid[k] !== 2'(b % 4)) begin n_err++; $display("FAIL rr_gid k=%0d got %0d want %0d", k, tr_gid[k], b % 4); end
      end
      if (exp_en) begin
        n_cmp++;
        if (tr_data[k] !== word(b % 4, j + ((b == 4) ? 9 : 0))) begin
          n_err++; $display("FAIL rr_data k=%0d got %h want %h", k, tr_data[k], word(b % 4, j + ((b == 4) ? 9 : 0)));
        end
      end
    end
    drain();
  endtask

  task automatic test_space();
    do_reset();
    water = 11'd1016; rem[2] = 18; drive_req(); tk = 0;
    repeat (4) tick();
    for (int k = 1; k <= 4; k++) begin
      n_cmp += 2;
      if (tr_busy[k] !== 1'b0) begin n_err++; $display("FAIL space_busy k=%0d got %b want 0", k, tr_busy[k]); end
      if (tr_ready[k] !== 4'b0) begin n_err++; $display("FAIL space_ready k=%0d got %b want 0", k, tr_ready[k]); end
    end
    water = 11'd1015; tk = 0;
    repeat (13) tick();
    n_cmp += 6;
    if (tr_busy[1] !== 1'b1)     begin n_err++; $display("FAIL space_grant got %b want 1", tr_busy[1]); end
    if (tr_gid[1] !== 2'd2)      begin n_err++; $display("FAIL space_gid got %0d want 2", tr_gid[1]); end
    if (tr_ready[1] !== 4'b0100) begin n_err++; $display("FAIL space_ready1 got %b want 0100", tr_ready[1]); end
    if (tr_busy[10] !== 1'b0)    begin n_err++; $display("FAIL space_end got %b want 0", tr_busy[10]); end
    if (tr_busy[11] !== 1'b0)    begin n_err++; $display("FAIL space_inflight got %b want 0", tr_busy[11]); end
    if (tr_busy[12] !== 1'b1)    begin n_err++; $display("FAIL space_regrant got %b want 1", tr_busy[12]); end
    drain();
    water = '0;
  endtask

  task automatic test_full_stall();
    logic exp_en;
    int nw;
    do_reset();
    rem[0] = 9; drive_req(); tk = 0; nw = 0;
    for (int k = 1; k <= 15; k++) begin
      fifo_full = (k >= 6 && k <= 8);
      tick();
    end
    fifo_full = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      exp_en = (k >= 2 && k <= 5) || (k >= 9 && k <= 13);
      if (tr_en[k]) nw++;
      n_cmp++;
      if (tr_en[k] !== exp_en) begin n_err++; $display("FAIL full_en k=%0d got %b want %b", k, tr_en[k], exp_en); end
      if (exp_en) begin
        n_cmp++;
        if (tr_data[k] !== word(0, (k <= 5) ? k - 1 : k - 4)) begin
          n_err++; $display("FAIL full_data k=%0d got %h want %h", k, tr_data[k], word(0, (k <= 5) ? k - 1 : k - 4));
        end
      end
    end
    n_cmp += 3;
    if (nw !== 9) begin n_err++; $display("FAIL full_count got %0d want 9", nw); end
    if (tr_ready[7] !== 4'b0) begin n_err++; $display("FAIL full_ready got %b want 0", tr_ready[7]); end
    if (tr_ready[9] !== 4'b0001) begin n_err++; $display("FAIL full_resume got %b want 0001", tr_ready[9]); end
    drain();
  endtask

  task automatic test_reset_mid();
    do_reset();
    rem[0] = 21; rem[1] = 9; drive_req(); tk = 0;
    repeat (4) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp += 5;
    if (tr_en[5] !== 1'b0)    begin n_err++; $display("FAIL mid_en got %b want 0", tr_en[5]); end
    if (tr_data[5] !== '0)    begin n_err++; $display("FAIL mid_data got %h want 0", tr_data[5]); end
    if (tr_busy[5] !== 1'b0)  begin n_err++; $display("FAIL mid_busy got %b want 0", tr_busy[5]); end
    if (tr_ready[5] !== 4'b0) begin n_err++; $display("FAIL mid_ready got %b want 0", tr_ready[5]); end
    if (tr_gid[5] !== 2'd0)   begin n_err++; $display("FAIL mid_gid got %0d want 0", tr_gid[5]); end
    repeat (11) tick();
    n_cmp += 4;
    if (tr_busy[6] !== 1'b1) begin n_err++; $display("FAIL mid_regrant got %b want 1", tr_busy[6]); end
    if (tr_gid[6] !== 2'd0)  begin n_err++; $display("FAIL mid_owner got %0d want 0", tr_gid[6]); end
    if (tr_en[16] !== 1'b0)  begin n_err++; $display("FAIL mid_end got %b want 0", tr_en[16]); end
    if (tr_gid[16] !== 2'd1) begin n_err++; $display("FAIL mid_next got %0d want 1", tr_gid[16]); end
    for (int k = 7; k <= 15; k++) begin
      n_cmp++;
      if (tr_en[k] !== 1'b1 || tr_data[k] !== word(0, k - 3)) begin
        n_err++; $display("FAIL mid_word k=%0d got %b/%h want 1/%h", k, tr_en[k], tr_data[k], word(0, k - 3));
      end
    end
    drain();
  endtask

`ifdef FIFO_ARB_PAD_EN
  task automatic test_pad();
    do_reset();
    rem[1] = 5; rem[2] = 9; drive_req(); tk = 0;
    repeat (28) tick();
    for (int k = 7; k <= 26; k++) begin
      n_cmp++;
      if (tr_en[k] !== (k >= 23)) begin n_err++; $display("FAIL pad_en k=%0d got %b want %b", k, tr_en[k], k >= 23); end
      if (k >= 23) begin
        n_cmp++;
        if (tr_data[k] !== '0) begin n_err++; $display("FAIL pad_data k=%0d got %h want 0", k, tr_data[k]); end
      end
    end
    n_cmp += 4;
    if (tr_pad[25] !== 1'b0)    begin n_err++; $display("FAIL pad_early got %b want 0", tr_pad[25]); end
    if (tr_pad[26] !== 1'b1)    begin n_err++; $display("FAIL pad_err got %b want 1", tr_pad[26]); end
    if (tr_ready[24] !== 4'b0)  begin n_err++; $display("FAIL pad_ready got %b want 0", tr_ready[24]); end
    if (tr_gid[27] !== 2'd2)    begin n_err++; $display("FAIL pad_next got %0d want 2", tr_gid[27]); end
    drain();
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; fifo_full = 1'b0; water = '0; req_valid = '0; req_data = '0;
    test_reset();
    test_single();
    test_all4();
    test_space();
    test_full_stall();
    test_reset_mid();
`ifdef FIFO_ARB_PAD_EN
    test_pad();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
